stream_fifo: RTL and testbench
==============================

// Module: stream_fifo
// PURPOSE
//  Parametrised synchronous FIFO with valid/ready handshakes on both sides and first-word-fall-through output.
//  Adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush and a sticky overflow flag.
//  Sits between AXI-stream producers/consumers in the dataflow (weights/pixels/outputs) as the general buffer.
// PARAMETERS
//  WIDTH     64    data width in bits
//  DEPTH     1024  capacity in words; power of 2, >= 4
//  AF_LEVEL  DEPTH-4  almost_full asserted when count >= AF_LEVEL
//  AE_LEVEL  4     almost_empty asserted when count <= AE_LEVEL
// PORTS
//  clk           in   1             clock, all logic on rising edge
//  reset         in   1             asynchronous, active-low reset
//  flush         in   1             synchronous clear of contents
//  s_valid       in   1             write-side data valid
//  s_ready       out  1             write-side ready (= !full)
//  s_data        in   WIDTH         write data
//  m_valid       out  1             read-side data valid (= !empty)
//  m_ready       in   1             read-side ready
//  m_data        out  WIDTH         head-of-queue word, valid when m_valid
//  count         out  $clog2(DEPTH)+1  words held (0..DEPTH)
//  almost_full   out  1             count >= AF_LEVEL
//  almost_empty  out  1             count <= AE_LEVEL
//  overflow      out  1             sticky: s_valid seen while s_ready low
// BEHAVIOUR
//  Reset (reset=0, async): count=0, pointers=0, s_ready=1, m_valid=0, m_data=0, almost_full=0 (AF_LEVEL>0),
//   almost_empty=1, overflow=0. Memory contents are not cleared.
//  push = s_valid & s_ready; pop = m_valid & m_ready. Both are evaluated on the same edge.
//  Pointers are $clog2(DEPTH)+1 bits (wrap bit); full = (addr equal, wrap differs); empty = pointers equal.
//   The full DEPTH words are usable.
//  count: +1 on push only, -1 on pop only, unchanged on push&pop. Registered; flags derive from registered count.
//  s_ready = (count != DEPTH); m_valid = (count != 0); both registered-state driven, never depend on s_valid/m_ready.
//  FWFT: m_data always shows the oldest word. A push into an empty FIFO at edge N gives m_valid=1 and m_data=word at N+1.
//  Pop at edge N presents the next word at N+1 (no bubble at full throughput).
//  Full + push&pop same cycle: not possible (s_ready=0). Empty + push&pop: pop ignored (m_valid=0), push accepted.
//  Sustained push&pop at any 0<count<DEPTH: 1 word/cycle both sides, count constant.
//  Wrap-around: addresses wrap modulo DEPTH; wrap bit toggles; order preserved indefinitely.
//  flush=1 at edge N: at N+1 count=0, m_valid=0, s_ready=1, pointers equal. Overrides push/pop on the same edge
//   (that word is dropped). overflow is NOT cleared by flush; only reset clears it.
//  overflow: set on any edge with s_valid=1 & s_ready=0; stays 1 until reset. Data is never written when full.
//  m_data holds its value while m_valid=1 & m_ready=0 (AXI stability). Value while m_valid=0 is don't-care.
//  Reset mid-operation: immediate return to reset state; in-flight words are discarded.
// STRUCTURE
//  fifo_pkg: typedef ptr_t (logic [$clog2(DEPTH):0]), cnt_t, a function returning next_ptr.
//  Sub-module fifo_sdp_ram: simple dual-port RAM, 1 write / 1 registered read, no reset, so it infers BRAM.
//  FWFT output register plus prefetch control live in stream_fifo. Read address = rd_ptr advanced on pop.
// TESTING
//  1. Reset, then 1 push of 0xA5 -> m_valid=1 next cycle, m_data=0xA5, count=1, almost_empty=1.
//  2. DEPTH=16: push 16 words 0..15 -> s_ready=0 after the 16th, count=16, almost_full=1. A 17th s_valid -> overflow=1,
//     and words 0..15 read back in order.
//  3. Continuous push&pop for 3*DEPTH cycles from count=5 -> count stays 5, output sequence intact across wraps.
//  4. count=8, flush with s_valid=1 -> next cycle count=0, m_valid=0, flushed word absent, overflow unchanged.
//  5. m_ready held low 10 cycles with m_valid=1 -> m_data stable. Random s_valid/m_ready 10k cycles vs scoreboard,
//     no loss or reorder.
//  6. Assert reset mid-burst (count=7) -> outputs at reset values asynchronously. Refill of 3 words returns only them.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and pointer helper for the stream FIFO.
// Pointers carry one extra wrap bit above the RAM address.
package fifo_pkg;

   localparam int unsigned FIFO_WIDTH = 64;
   localparam int unsigned FIFO_DEPTH = 1024;
   localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH) + 1;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W-1:0] cnt_t;

   // DEPTH is a power of two, so a plain increment wraps address and toggles the wrap bit
   function automatic ptr_t next_ptr(input ptr_t ptr);
      return ptr + 1'b1;
   endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// No reset so the array maps onto block RAM.
module fifo_sdp_ram #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      o_rd_data <= r_mem[i_rd_addr];
   end

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with occupancy, watermark flags,
// synchronous flush and sticky overflow.
module stream_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH    = FIFO_WIDTH,
   parameter int unsigned DEPTH    = FIFO_DEPTH,
   parameter int unsigned AF_LEVEL = DEPTH - 4,
   parameter int unsigned AE_LEVEL = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [WIDTH-1:0]       s_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [WIDTH-1:0]       m_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic                   overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
   localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

   logic [PW-1:0]    r_wr_ptr, r_rd_ptr, r_count;
   logic [PW-1:0]    w_wr_next, w_rd_next, w_head;
   logic             w_push, w_pop;
   logic             r_overflow, r_bypass;
   logic [WIDTH-1:0] r_byp_data, w_ram_q;

   assign s_ready      = (r_count != DEPTH_C);
   assign m_valid      = (r_count != '0);
   assign w_push       = s_valid & s_ready;
   assign w_pop        = m_valid & m_ready;
   assign w_wr_next    = PW'(next_ptr(ptr_t'(r_wr_ptr)));
   assign w_rd_next    = PW'(next_ptr(ptr_t'(r_rd_ptr)));
   assign w_head       = w_pop ? w_rd_next : r_rd_ptr;
   assign count        = r_count;
   assign almost_full  = (r_count >= AF_C);
   assign almost_empty = (r_count <= AE_C);
   assign overflow     = r_overflow;

   // RAM reads before write, so a word landing on the new head slot comes from the bypass register
   assign m_data = r_bypass ? r_byp_data : w_ram_q;

   fifo_sdp_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_push & ~flush),
      .i_wr_addr (r_wr_ptr[AW-1:0]),
      .i_wr_data (s_data),
      .i_rd_addr (w_head[AW-1:0]),
      .o_rd_data (w_ram_q)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_bypass   <= 1'b1;
         r_byp_data <= '0;
      end else begin
         if (s_valid && !s_ready) r_overflow <= 1'b1;
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= w_wr_next;
            if (w_pop)  r_rd_ptr <= w_rd_next;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            r_bypass <= w_push && (w_head == r_wr_ptr);
            if (w_push) r_byp_data <= s_data;
         end
      end
   end

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo (DEPTH=16): directed sequences plus a random phase,
// with a queue scoreboard drained by a negedge monitor.
module tb_stream_fifo;

   localparam int DEPTH = 16;
   localparam int WIDTH = 64;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             flush = 1'b0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [WIDTH-1:0] s_data = '0;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [WIDTH-1:0] m_data;
   logic [4:0]       count;
   logic             almost_full, almost_empty, overflow;

   int               n_checks = 0;
   int               n_errors = 0;
   int               mcount = 0;
   bit               mon_en = 1'b0;
   logic [WIDTH-1:0] exp_q[$];

   stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; the model commits after the edge it describes
   task automatic step(input logic sv, input logic [WIDTH-1:0] sd, input logic mr, input logic fl = 1'b0);
      logic acc, pp;
      s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
      acc = sv && (mcount != DEPTH);
      pp  = mr && (mcount != 0);
      @(posedge clk); #1;
      if (fl) begin
         exp_q.delete();
         mcount = 0;
      end else begin
         if (acc) exp_q.push_back(sd);
         mcount = mcount + int'(acc) - int'(pp);
      end
      s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) step(1'b0, '0, 1'b1);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("m_valid_vs_model", {63'd0, m_valid}, {63'd0, mcount != 0});
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL pop_unexpected: got %0h expected no word", m_data);
            end else begin
               chk("pop_data", m_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd1);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", m_data, 64'd0);
      chk("rst_af", 64'(almost_full), 64'd0);
      chk("rst_ae", 64'(almost_empty), 64'd1);
      chk("rst_ovf", 64'(overflow), 64'd0);
      reset = 1'b1;
      mon_en = 1'b1;

      step(1'b1, 64'hA5, 1'b0);
      chk("t1_m_valid", 64'(m_valid), 64'd1);
      chk("t1_m_data", m_data, 64'hA5);
      chk("t1_count", 64'(count), 64'd1);
      chk("t1_ae", 64'(almost_empty), 64'd1);
      drain(1);

      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 64'(i), 1'b0);
         chk("t2_count", 64'(count), 64'(i + 1));
         chk("t2_af", 64'(almost_full), 64'(i + 1 >= 12));
         chk("t2_ae", 64'(almost_empty), 64'(i + 1 <= 4));
      end
      chk("t2_s_ready_full", 64'(s_ready), 64'd0);
      chk("t2_ovf_before", 64'(overflow), 64'd0);
      step(1'b1, 64'h99, 1'b0);
      chk("t2_ovf_set", 64'(overflow), 64'd1);
      chk("t2_count_held", 64'(count), 64'd16);
      drain(DEPTH);
      chk("t2_empty", 64'(count), 64'd0);

      for (int i = 0; i < 5; i++) step(1'b1, 64'(100 + i), 1'b0);
      for (int i = 0; i < 3 * DEPTH; i++) begin
         step(1'b1, 64'(200 + i), 1'b1);
         chk("t3_count", 64'(count), 64'd5);
      end
      drain(5);

      for (int i = 0; i < 8; i++) step(1'b1, 64'(300 + i), 1'b0);
      chk("t4_count8", 64'(count), 64'd8);
      step(1'b1, 64'hDEAD, 1'b0, 1'b1);
      chk("t4_count0", 64'(count), 64'd0);
      chk("t4_m_valid", 64'(m_valid), 64'd0);
      chk("t4_s_ready", 64'(s_ready), 64'd1);
      chk("t4_ovf_kept", 64'(overflow), 64'd1);
      step(1'b1, 64'd400, 1'b0);
      step(1'b1, 64'd401, 1'b0);
      drain(3);

      for (int i = 0; i < 3; i++) step(1'b1, 64'(500 + i), 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, '0, 1'b0);
         chk("t5_stable", m_data, 64'd500);
      end
      for (int i = 0; i < 10000; i++)
         step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      drain(DEPTH + 2);
      chk("t5_empty", 64'(count), 64'd0);

      for (int i = 0; i < 7; i++) step(1'b1, 64'(600 + i), 1'b0);
      chk("t6_count7", 64'(count), 64'd7);
      #2;
      reset = 1'b0;
      exp_q.delete();
      mcount = 0;
      #1;
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_m_valid", 64'(m_valid), 64'd0);
      chk("t6_s_ready", 64'(s_ready), 64'd1);
      chk("t6_m_data", m_data, 64'd0);
      chk("t6_ae", 64'(almost_empty), 64'd1);
      chk("t6_ovf", 64'(overflow), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 64'(700 + i), 1'b0);
      chk("t6_refill", 64'(count), 64'd3);
      drain(5);
      chk("t6_final", 64'(count), 64'd0);
      chk("t6_q_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
